// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared types and RV32I load/store width codes for the ysyx_25020047 LSU.
package ysyx_25020047_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic: load extraction/extension, store strobes/replication,
// illegal-width and (with LSU_MISALIGN_TRAP_EN defined) misalignment detection.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        illegal,
  output logic        misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val   = 8'h00;
    half_val   = 16'h0000;
    load_data  = 32'h0;
    wdata      = 32'h0;
    wstrb      = 4'b0000;
    illegal    = 1'b0;
    misaligned = 1'b0;

    case (lane)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_data = {24'h0, byte_val};
      F3_H:    load_data = {{16{half_val[15]}}, half_val};
      F3_HU:   load_data = {16'h0, half_val};
      F3_W:    load_data = rdata;
      default: load_data = 32'h0;
    endcase

    // Reads never carry byte enables; only the three store widths drive lanes.
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wstrb = 4'b0001 << lane;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          wstrb = 4'b0011 << {lane[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        F3_W: begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
        default: begin
          wstrb = 4'b0000;
          wdata = 32'h0;
        end
      endcase
    end

    if (is_load) begin
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                  funct3 == F3_BU || funct3 == F3_HU);
    end else if (is_store) begin
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (is_load || is_store) &&
                 ((((funct3 == F3_H) || (funct3 == F3_HU)) && lane[0]) ||
                  ((funct3 == F3_W) && (lane != 2'b00)));
`else
    misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit feeding writeback; optional misalignment trap via
// LSU_MISALIGN_TRAP_EN. FSM, timeout counter and result holding live here.
module ysyx_25020047_lsu
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       memdata,
  output logic              access_fault
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic [7:0]  wait_cnt_reg;

  logic        idle;
  logic        sel_load;
  logic        sel_store;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_lane;
  logic [31:0] load_data;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        illegal;
  logic        misaligned;

  assign idle     = (state == IDLE);
  assign in_ready = idle;

  // In IDLE the aligner classifies the incoming op; afterwards it works on the
  // latched op (mem_req_wen doubles as the latched store flag).
  assign sel_load   = idle ? is_load    : !mem_req_wen;
  assign sel_store  = idle ? is_store   : mem_req_wen;
  assign sel_funct3 = idle ? funct3     : funct3_reg;
  assign sel_lane   = idle ? addr[1:0]  : lane_reg;

  ysyx_25020047_lsu_align u_align (
    .is_load    (sel_load),
    .is_store   (sel_store),
    .funct3     (sel_funct3),
    .lane       (sel_lane),
    .store_data (store_data),
    .rdata      (mem_resp_rdata),
    .load_data  (load_data),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      funct3_reg    <= 3'd0;
      lane_reg      <= 2'd0;
      wait_cnt_reg  <= 8'd0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= 32'h0;
      mem_req_wstrb <= 4'b0000;
      out_valid     <= 1'b0;
      memdata       <= 32'h0;
      access_fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            funct3_reg   <= funct3;
            lane_reg     <= addr[1:0];
            memdata      <= 32'h0;
            access_fault <= 1'b0;
            if (!is_load && !is_store) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (illegal || misaligned) begin
              state        <= DONE;
              out_valid    <= 1'b1;
              access_fault <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_wen   <= is_store;
              mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_req_wdata <= wdata;
              mem_req_wstrb <= wstrb;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt_reg  <= 8'd0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (mem_resp_valid) begin
            memdata   <= mem_req_wen ? 32'h0 : load_data;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            memdata      <= 32'h0;
            access_fault <= 1'b1;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for ysyx_25020047_lsu: memory responder, output monitor and
// a behavioural reference model driven by directed and random operations.
module tb_ysyx_25020047_lsu;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] memdata;
  logic        access_fault;

  always #5 clk = ~clk;

  ysyx_25020047_lsu #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .memdata(memdata), .access_fault(access_fault)
  );

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          rdy_d;
    int          rsp_d;
    bit          no_resp;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] md;
    bit          fault;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  int    r_state = 0;
  int    r_cnt = 0;
  plan_t cur;
  int    abort_gen = 0;
  int    abort_seen = 0;
  bit    hold_active = 1'b0;
  int    done_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: straight from the width/lane rules, byte arithmetic only.
  function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input bit tmo,
                                output bit bus, output bit flt, output logic [31:0] md,
                                output logic [3:0] strb, output logic [31:0] wd);
    int size;
    int off;
    bit legal;
    logic [31:0] mask;
    logic [31:0] v;
    bus = 0; flt = 0; md = 32'h0; strb = 4'h0; wd = 32'h0;
    if (!ld && !st) return;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (ld && (f3 == 3'd4 || f3 == 3'd5));
    size = 1 << (f3 % 4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (a % size) != 0) legal = 0;
`endif
    if (!legal) begin
      flt = 1;
      return;
    end
    bus = 1;
    off = (size == 4) ? 0 : ((a % 4) / size) * size;
    if (st) begin
      strb = 4'((32'd1 << size) - 1) << off;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    if (tmo) begin
      flt = 1;
    end else if (ld) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
      v = (rd >> (8*off)) & mask;
      if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      md = v;
    end
  endfunction

  task automatic check_req();
    chk("req_valid", mem_req_valid, 1'b1);
    chk("req_wen", mem_req_wen, cur.wen);
    chk("req_addr", mem_req_addr, cur.addr);
    chk("req_wstrb", mem_req_wstrb, cur.strb);
    if (cur.wen) chk("req_wdata", mem_req_wdata, cur.wdata);
  endtask

  task automatic grant_step();
    if (r_cnt == 0) begin
      mem_req_ready = 1'b1;
      if (cur.no_resp) r_state = 0;
      else begin
        r_cnt = cur.rsp_d;
        r_state = 2;
      end
    end else begin
      r_cnt--;
      r_state = 1;
    end
  endtask

  // Memory responder: checks request fields against the plan, then acks.
  always @(negedge clk) begin
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    if (abort_seen != abort_gen) begin
      abort_seen = abort_gen;
      r_state = 0;
    end else begin
      case (r_state)
        0: if (mem_req_valid) begin
          if (plan_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual_addr=%h required=no_request", mem_req_addr);
          end else begin
            cur = plan_q.pop_front();
            r_cnt = cur.rdy_d;
            check_req();
            grant_step();
          end
        end
        1: begin
          if (!rst) check_req();
          grant_step();
        end
        2: begin
          if (r_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = cur.rdata;
            r_state = 0;
          end else r_cnt--;
        end
        default: r_state = 0;
      endcase
    end
  end

  // Output monitor: compares held result every DONE cycle, pops on handshake.
  always @(negedge clk) begin
    if (out_valid) begin
      done_cycles++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual_memdata=%h required=no_output", memdata);
      end else begin
        chk("memdata", memdata, exp_q[0].md);
        chk("access_fault", access_fault, exp_q[0].fault);
        chk("in_ready_done", in_ready, 1'b0);
      end
    end else begin
      done_cycles = 0;
    end
    if (hold_active && out_valid && done_cycles <= 4) out_ready = 1'b0;
    else out_ready = ($urandom_range(3) != 0);
    if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int rdy_d, input int rsp_d, input bit no_resp,
                        input logic [31:0] rd);
    bit bus, flt, tmo;
    logic [31:0] md, wd;
    logic [3:0] strb;
    plan_t p;
    exp_t e;
    int lat, exp_lat, b;
    tmo = no_resp || (rsp_d >= TMO);
    model(ld, st, f3, a, sd, rd, tmo, bus, flt, md, strb, wd);
    exp_lat = bus ? (3 + rdy_d + (tmo ? TMO - 1 : rsp_d)) : 1;
    if (bus) begin
      p.wen = st; p.addr = {a[31:2], 2'b00}; p.strb = strb; p.wdata = wd;
      p.rdy_d = rdy_d; p.rsp_d = rsp_d; p.no_resp = no_resp; p.rdata = rd;
      plan_q.push_back(p);
    end
    e.md = md; e.fault = flt;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("accept", in_ready, 1'b1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 100);
    chk("latency", lat, exp_lat);
    b = 0;
    while ((exp_q.size() != 0 || r_state != 0) && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
      exp_q.delete();
      plan_q.delete();
    end
    $display("op ld=%0d st=%0d f3=%0d addr=%h sdata=%h rdata=%h -> memdata=%h fault=%0d lat=%0d",
             ld, st, f3, a, sd, rd, md, flt, exp_lat);
  endtask

  // Start a word load and stop before completion; returns once accepted.
  task automatic start_lw(input logic [31:0] a, input int rdy_d, input int rsp_d);
    plan_t p;
    int b;
    p.wen = 0; p.addr = {a[31:2], 2'b00}; p.strb = 4'h0; p.wdata = 32'h0;
    p.rdy_d = rdy_d; p.rsp_d = rsp_d; p.no_resp = 0; p.rdata = 32'h1234_5678;
    plan_q.push_back(p);
    @(negedge clk);
    in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = a;
    b = 0;
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, st;
    logic [2:0] f3;
    int kind;
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] bad_f3[3] = '{3'd3, 3'd6, 3'd7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_memdata", memdata, 32'h0);
    chk("rst_fault", access_fault, 1'b0);
    chk("rst_wstrb", mem_req_wstrb, 4'h0);

    run_op(1, 0, 3'd0, 32'h8000_0003, 32'h0, 0, 0, 0, 32'h80AA_5511);
    run_op(1, 0, 3'd5, 32'h8000_0002, 32'h0, 0, 0, 0, 32'hBEEF_1234);
    run_op(1, 0, 3'd2, 32'h8000_0004, 32'h0, 0, 0, 0, 32'hCAFE_F00D);
    run_op(0, 1, 3'd0, 32'h8000_0001, 32'h0000_00A5, 0, 0, 0, 32'h0);
    run_op(0, 1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 0, 1, 0, 32'h0);
    run_op(0, 1, 3'd2, 32'h8000_0008, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    run_op(1, 0, 3'd2, 32'h8000_0010, 32'h0, 5, 0, 1, 32'h0);
    run_op(1, 0, 3'd0, 32'h8000_0005, 32'h0, 0, TMO - 1, 0, 32'h0000_7F00);
    run_op(1, 0, 3'd1, 32'h8000_0006, 32'h0, 0, TMO, 0, 32'h8001_0000);
    hold_active = 1'b1;
    run_op(1, 0, 3'd1, 32'h8000_0006, 32'h0, 0, 0, 0, 32'h8001_0000);
    hold_active = 1'b0;
    run_op(0, 0, 3'd0, 32'h8000_0000, 32'h0, 0, 0, 0, 32'h0);
    run_op(1, 0, 3'd3, 32'h8000_0000, 32'h0, 0, 0, 0, 32'h0);
    run_op(0, 1, 3'd4, 32'h8000_0000, 32'h0, 0, 0, 0, 32'h0);
    run_op(1, 0, 3'd2, 32'h8000_0002, 32'h0, 0, 0, 0, 32'h0BAD_CAFE);

    // Reset while the request is pending: request must drop at once.
    start_lw(32'h8000_0020, 10, 0);
    @(negedge clk);
    chk("req_before_rst", mem_req_valid, 1'b1);
    abort_gen++;
    rst = 1'b1;
    #1;
    chk("rst_drops_req", mem_req_valid, 1'b0);
    chk("rst_in_ready_mid", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in WAIT: the late response must be ignored (monitor flags any output).
    start_lw(32'h8000_0024, 0, 6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wait_req", mem_req_valid, 1'b0);
    chk("rst_wait_out", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("stale_resp_out", out_valid, 1'b0);
    chk("stale_resp_memdata", memdata, 32'h0);
    run_op(1, 0, 3'd4, 32'h8000_0027, 32'h0, 0, 0, 0, 32'hF1E2_D3C4);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(19);
      ld = 0; st = 0;
      if (kind == 0) begin
        f3 = 3'($urandom_range(7));
      end else if (kind == 1) begin
        ld = 1; f3 = bad_f3[$urandom_range(2)];
      end else if (kind == 2) begin
        st = 1; f3 = 3'(3 + $urandom_range(4));
      end else if (kind < 11) begin
        ld = 1; f3 = ld_f3[$urandom_range(4)];
      end else begin
        st = 1; f3 = 3'($urandom_range(2));
      end
      hold_active = ($urandom_range(7) == 0);
      run_op(ld, st, f3, 32'h8000_0000 | ($urandom & 32'hFF), $urandom,
             ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(15) == 0) ? TMO + 2 : $urandom_range(0, 3),
             ($urandom_range(31) == 0), $urandom);
    end
    hold_active = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
